// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_arbiter (with barrel_shifter_4bit)
//  Brief    : Round-robin share of one 4-bit left barrel shifter between
//             NUM_REQ valid/ready requesters, single registered result slot.
//             Optional rotate mode: define SHARB_ROTATE_EN.
//  Revision : 1.0 - initial release
// ============================================================================

module barrel_shifter_4bit (
    input  logic [3:0] i_data,
    input  logic [1:0] i_amt,
    input  logic       i_rot,
    output logic [3:0] o_data
);

    logic [3:0] w_shl;

    assign w_shl = i_data << i_amt;

`ifdef SHARB_ROTATE_EN
    logic [3:0] w_rol;

    // amt=0 shifts right by 4, which zero-fills and leaves the operand intact
    assign w_rol  = w_shl | (i_data >> (3'd4 - {1'b0, i_amt}));
    assign o_data = i_rot ? w_rol : w_shl;
`else
    logic w_unused_rot;

    assign w_unused_rot = i_rot;
    assign o_data       = w_shl;
`endif

endmodule

module shifter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_data,
    input  logic [2*NUM_REQ-1:0] req_amt,
    input  logic [NUM_REQ-1:0]   req_rot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_data,
    output logic [ID_W-1:0]      out_id
);

    logic               r_out_valid;
    logic [3:0]         r_out_data;
    logic [ID_W-1:0]    r_out_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_slot_free;
    logic               w_grant_valid;
    logic [ID_W-1:0]    w_grant_idx;
    logic [ID_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [3:0]         w_sel_data;
    logic [1:0]         w_sel_amt;
    logic               w_sel_rot;
    logic [3:0]         w_shift_result;

    assign w_slot_free = !r_out_valid || out_ready;

    // Scan from the farthest candidate down to rr_ptr so the nearest valid
    // requester (searching upward with wrap) is the last one written.
    always_comb begin
        int idx;
        int nidx;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_next_ptr    = '0;
        w_req_ready   = '0;
        w_sel_data    = '0;
        w_sel_amt     = '0;
        w_sel_rot     = 1'b0;
        idx           = 0;
        nidx          = 0;
        if (!rst && w_slot_free) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (req_valid[idx]) begin
                    nidx          = (idx + 1 == NUM_REQ) ? 0 : idx + 1;
                    w_grant_valid = 1'b1;
                    w_grant_idx   = ID_W'(idx);
                    w_next_ptr    = ID_W'(nidx);
                    w_sel_data    = req_data[idx*4 +: 4];
                    w_sel_amt     = req_amt[idx*2 +: 2];
                    w_sel_rot     = req_rot[idx];
                end
            end
        end
        if (w_grant_valid) w_req_ready[w_grant_idx] = 1'b1;
    end

    barrel_shifter_4bit u_shifter (
        .i_data (w_sel_data),
        .i_amt  (w_sel_amt),
        .i_rot  (w_sel_rot),
        .o_data (w_shift_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_shift_result;
            r_out_id    <= w_grant_idx;
            r_rr_ptr    <= w_next_ptr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shifter_arbiter
//  Brief    : Directed self-checking bench for shifter_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_shifter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0] req_amt;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_data;
    logic [ID_W-1:0]      out_id;

    int errors;
    int checks;

    shifter_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_rot   (req_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_rot   = '0;
        out_ready = 1'b1;
        // lanes: 1<<0=1, 3<<1=6, 5<<2=4, F<<3=8
        req_data  = 16'hF531;
        req_amt   = 8'b11_10_01_00;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_rot   = '0;
        out_ready = 1'b1;
        req_data  = 16'hF531;
        req_amt   = 8'b11_10_01_00;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: got %b want 0000", c, req_ready);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid);
            end
        end
        checks++;
        if (out_data !== 4'h0 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_regs: data=%h id=%0d want 0/0", out_data, out_id);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 4'h1) begin
            errors++;
            $display("FAIL reset_first_result: v=%b id=%0d data=%h want 1/0/1", out_valid, out_id, out_data);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_data[11:8] = 4'b1011;
        req_amt[5:4]   = 2'd1;
        req_valid      = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL single_result: v=%b data=%b id=%0d want 1/0110/2", out_valid, out_data, out_id);
        end
        req_data[11:8] = 4'b0001;
        req_amt[5:4]   = 2'd3;
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1000 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL single_amt3: v=%b data=%b id=%0d want 1/1000/2", out_valid, out_data, out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'b1000 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL single_drain: v=%b data=%b id=%0d want 0/1000/2", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data [4];
        exp_data[0] = 4'h1;
        exp_data[1] = 4'h6;
        exp_data[2] = 4'h4;
        exp_data[3] = 4'h8;
        apply_reset();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== exp_data[k % 4]) begin
                errors++;
                $display("FAIL rr_step%0d: v=%b id=%0d data=%h want 1/%0d/%h",
                         k, out_valid, out_id, out_data, k % 4, exp_data[k % 4]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 4'b0010;
        tick();
        out_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready cyc%0d: got %b want 0000", c, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 4'h6) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: v=%b id=%0d data=%h want 1/1/6", c, out_valid, out_id, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 4'h4) begin
            errors++;
            $display("FAIL bp_release_result: v=%b id=%0d data=%h want 1/2/4", out_valid, out_id, out_data);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = '1;
        rst       = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: v=%b ready=%b want 0/0000", out_valid, req_ready);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_ptr: ready=%b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_result: v=%b id=%0d want 1/0", out_valid, out_id);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp;
`ifdef SHARB_ROTATE_EN
        exp = 4'b0110;
`else
        exp = 4'b0100;
`endif
        apply_reset();
        req_data[3:0] = 4'b1001;
        req_amt[1:0]  = 2'd2;
        req_rot       = 4'b0001;
        req_valid     = 4'b0001;
        tick();
        req_valid = '0;
        req_rot   = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL rotate: v=%b data=%b want 1/%b", out_valid, out_data, exp);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_rot   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_rotate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
